// File: rtl/ps2_key_fifo_pkg.sv
// ps2_key_fifo_pkg: shared address, vector, read-word layout and IRQ states for the keyboard FIFO.
package ps2_key_fifo_pkg;

    localparam logic [31:0] Key_base      = 32'h0000_0040;
    localparam logic [3:0]  KEY_VECTOR    = 4'd1;
    localparam int          KEY_VALID_BIT = 8;
    localparam int          KEY_OVF_BIT   = 9;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_PEND,
        IRQ_ACKED
    } irq_state_e;

    function automatic logic [63:0] key_word(input logic ovf, input logic valid, input logic [7:0] code);
        logic [63:0] w;
        w                = 64'd0;
        w[7:0]           = code;
        w[KEY_VALID_BIT] = valid;
        w[KEY_OVF_BIT]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/ps2_key_fifo_sync_fifo.sv
// sync_fifo: power-of-two circular buffer; a pop on a full FIFO lets a same-cycle push land.
module sync_fifo
    import ps2_key_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: buffers decoded keystrokes for the slow CPU, serves them at Key_base
// and raises the keyboard interrupt until acknowledged.
module ps2_key_fifo
    import ps2_key_fifo_pkg::*;
#(
    parameter int         DEPTH      = 8,
    parameter logic [3:0] KEY_VECTOR = ps2_key_fifo_pkg::KEY_VECTOR
) (
    input  logic                   CLOCK_50,
    input  logic                   KEY0,
    input  logic                   key_pressed,
    input  logic [7:0]             ascii,
    input  logic                   bus_read_enable,
    input  logic                   key_selected,
    output logic [63:0]            key_read_data,
    output logic [3:0]             interrupt_vector,
    input  logic                   interrupt_ack,
    output logic [$clog2(DEPTH):0] fifo_count
);

    logic                   key_q;
    logic                   rd_q;
    logic                   ovf_q;
    logic                   ovf_d;
    logic [63:0]            word_q;
    logic [63:0]            word_d;
    irq_state_e             irq_q;
    logic [3:0]             vec_q;
    logic                   rd_req;
    logic                   push;
    logic                   pop;
    logic [7:0]             head;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;

    // Both strobes are level signals held for many cycles; act only on their rising edges.
    assign rd_req = bus_read_enable & key_selected;
    assign push   = key_pressed & ~key_q & (ascii != 8'd0);
    assign pop    = rd_req & ~rd_q;

    // A pop always frees a slot, so a push coinciding with it is never an overflow.
    assign ovf_d  = pop ? 1'b0 : (push & full) ? 1'b1 : ovf_q;
    assign word_d = pop ? key_word(ovf_q, ~empty, empty ? 8'd0 : head) : word_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst_n   (KEY0),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ascii),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            key_q  <= 1'b0;
            rd_q   <= 1'b0;
            ovf_q  <= 1'b0;
            word_q <= '0;
        end else begin
            key_q  <= key_pressed;
            rd_q   <= rd_req;
            ovf_q  <= ovf_d;
            word_q <= word_d;
        end
    end

    // The ISR drains the FIFO by reading Key_base; the FSM only tracks the ack handshake.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            irq_q <= IRQ_IDLE;
            vec_q <= '0;
        end else begin
            case (irq_q)
                IRQ_IDLE: if (count != '0) begin
                    irq_q <= IRQ_PEND;
                    vec_q <= KEY_VECTOR;
                end
                IRQ_PEND: if (interrupt_ack) begin
                    irq_q <= IRQ_ACKED;
                    vec_q <= '0;
                end
                IRQ_ACKED: if (!interrupt_ack) irq_q <= IRQ_IDLE;
                default: begin
                    irq_q <= IRQ_IDLE;
                    vec_q <= '0;
                end
            endcase
        end
    end

    assign key_read_data    = word_q;
    assign interrupt_vector = vec_q;
    assign fifo_count       = count;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb_ps2_key_fifo: directed stimulus with a read-word scoreboard checked by a separate monitor.
module tb_ps2_key_fifo;

    logic        clk = 1'b0;
    logic        KEY0 = 1'b0;
    logic        key_pressed = 1'b0;
    logic [7:0]  ascii = 8'd0;
    logic        bus_read_enable = 1'b0;
    logic        key_selected = 1'b0;
    logic        interrupt_ack = 1'b0;
    logic [63:0] key_read_data;
    logic [3:0]  interrupt_vector;
    logic [3:0]  fifo_count;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    logic        rd_prev = 1'b0;
    logic        pop_seen = 1'b0;

    always #10 clk = ~clk;

    ps2_key_fifo #(.DEPTH(8), .KEY_VECTOR(4'd1)) dut (
        .CLOCK_50         (clk),
        .KEY0             (KEY0),
        .key_pressed      (key_pressed),
        .ascii            (ascii),
        .bus_read_enable  (bus_read_enable),
        .key_selected     (key_selected),
        .key_read_data    (key_read_data),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack),
        .fifo_count       (fifo_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        pop_seen = KEY0 && bus_read_enable && key_selected && !rd_prev;
        rd_prev  = KEY0 && bus_read_enable && key_selected;
    end

    always @(negedge clk) begin
        if (pop_seen) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL read: unexpected pop, got %h expected none", key_read_data);
            end else begin
                check("read", key_read_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input string name, input logic [63:0] act_sel, input logic [63:0] exp);
        check(name, act_sel, exp);
    endtask

    task automatic check_count(input string name, input logic [63:0] exp);
        @(negedge clk);
        check(name, {60'd0, fifo_count}, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [63:0] exp);
        @(negedge clk);
        check(name, {60'd0, interrupt_vector}, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vec(input string name, input logic [3:0] exp, input int n);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (interrupt_vector == exp) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: vector %0d, required %0d within %0d cycles", name, interrupt_vector, exp, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] a, input int hold);
        ascii = a;
        key_pressed = 1'b1;
        tick(hold);
        key_pressed = 1'b0;
        ascii = 8'd0;
        tick(1);
    endtask

    task automatic read(input logic [63:0] exp, input int hold);
        exp_q.push_back(exp);
        bus_read_enable = 1'b1;
        key_selected = 1'b1;
        tick(hold);
        bus_read_enable = 1'b0;
        key_selected = 1'b0;
        tick(1);
    endtask

    task automatic ack_cycle();
        interrupt_ack = 1'b1;
        tick(2);
        interrupt_ack = 1'b0;
        tick(2);
    endtask

    task automatic both_edges(input logic [7:0] a, input logic [63:0] exp);
        exp_q.push_back(exp);
        ascii = a;
        key_pressed = 1'b1;
        bus_read_enable = 1'b1;
        key_selected = 1'b1;
        tick(3);
        key_pressed = 1'b0;
        ascii = 8'd0;
        bus_read_enable = 1'b0;
        key_selected = 1'b0;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("reset data", key_read_data, 64'd0);
        check("reset vector", {60'd0, interrupt_vector}, 64'd0);
        check("reset count", {60'd0, fifo_count}, 64'd0);
        KEY0 = 1'b1;
        tick(2);
        read(64'h000, 3);

        // single key, long strobes
        ascii = 8'h41;
        key_pressed = 1'b1;
        wait_vec("irq raise", 4'd1, 3);
        tick(97);
        key_pressed = 1'b0;
        ascii = 8'd0;
        tick(1);
        check_count("count after A", 1);
        read(64'h141, 50);
        check_count("count after read A", 0);
        interrupt_ack = 1'b1;
        tick(1);
        check_vec("ack drops vector", 0);
        interrupt_ack = 1'b0;
        tick(2);
        check_vec("idle empty vector", 0);

        // overflow
        for (int i = 0; i < 9; i++) press(8'h61 + 8'(i), 2);
        check_count("count full", 8);
        read(64'h361, 5);
        read(64'h162, 5);
        for (int i = 0; i < 6; i++) read(64'h163 + 64'(i), 5);
        read(64'h000, 5);
        check_count("count drained", 0);
        ack_cycle();

        // IRQ handshake without reading
        press(8'h71, 2);
        press(8'h72, 2);
        wait_vec("irq two bytes", 4'd1, 4);
        interrupt_ack = 1'b1;
        tick(1);
        check_vec("acked vector", 0);
        tick(2);
        check_vec("acked held", 0);
        interrupt_ack = 1'b0;
        wait_vec("irq re-raise", 4'd1, 4);
        check_count("count kept", 2);
        read(64'h171, 4);
        read(64'h172, 4);
        ack_cycle();

        // push and pop edge together at full
        for (int i = 0; i < 8; i++) press(8'h31 + 8'(i), 2);
        check_count("count full 2", 8);
        both_edges(8'h39, 64'h131);
        check_count("count full same", 8);
        read(64'h132, 3);
        for (int i = 0; i < 7; i++) read(64'h133 + 64'(i), 3);
        tick(4);
        sample("data holds", key_read_data, 64'h139);
        check_count("count drained 2", 0);

        // push and pop edge together at empty
        both_edges(8'h5A, 64'h000);
        check_count("count after empty both", 1);
        read(64'h15A, 3);
        check_count("count drained 3", 0);
        ack_cycle();

        // asynchronous reset mid-read
        for (int i = 0; i < 5; i++) press(8'h41 + 8'(i), 2);
        check_count("count five", 5);
        tick(3);
        exp_q.push_back(64'h141);
        bus_read_enable = 1'b1;
        key_selected = 1'b1;
        tick(3);
        KEY0 = 1'b0;
        #1;
        check("async data", key_read_data, 64'd0);
        check("async vector", {60'd0, interrupt_vector}, 64'd0);
        check("async count", {60'd0, fifo_count}, 64'd0);
        bus_read_enable = 1'b0;
        key_selected = 1'b0;
        tick(2);
        KEY0 = 1'b1;
        tick(3);
        check_vec("post reset vector", 0);
        read(64'h000, 3);
        press(8'h42, 2);
        wait_vec("irq from idle", 4'd1, 3);
        read(64'h142, 3);

        tick(2);
        check("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_fifo.md
Name: ps2_key_fifo

Overview:
- Buffers ASCII bytes from the PS/2 decoder in a small FIFO, so keystrokes arriving while the 1 Hz CPU is busy are not lost.
- Presents the bytes to the bus read multiplexer at the Key_base address.
- Raises the keyboard interrupt vector toward the CPU and clears it on the CPU's interrupt_ack handshake.
- Sits between ps2_decoder and the bus controller / CPU interrupt input, and replaces the single-register key path.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- KEY_VECTOR, 4'd1, value driven on interrupt_vector while a key interrupt is pending.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- KEY0  input  1  asynchronous active-low reset.
- key_pressed  input  1  level from ps2_decoder; high while the make code is valid.
- ascii  input  8  ASCII code from ps2_decoder; 0 means no printable key.
- bus_read_enable  input  1  CPU bus read strobe; may stay high for many CLOCK_50 cycles.
- key_selected  input  1  address decode hit on Key_base.
- key_read_data  output  64  read word {32'd0, 22'd0, overflow, valid, ascii[7:0]}.
- interrupt_vector  output  4  KEY_VECTOR when pending, else 0.
- interrupt_ack  input  1  CPU acknowledge level.
- fifo_count  output  $clog2(DEPTH)+1  occupancy, for the debug LEDs.

Behaviour:
- Reset is asynchronous on KEY0 low:
  - pointers and count are cleared;
  - key_read_data = 0, interrupt_vector = 0, fifo_count = 0;
  - the overflow sticky bit is cleared;
  - the IRQ FSM goes to IDLE.
- Push event:
  - fires on the rising edge of key_pressed (registered delay of one cycle) with ascii != 0;
  - writes ascii at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop event:
  - fires on the rising edge of (bus_read_enable && key_selected);
  - exactly one pop per CPU read, however long the strobe is held.
- Read latency is 1 cycle after the pop edge:
  - key_read_data = {.., overflow, 1'b1, head} and rd_ptr advances;
  - if the FIFO is empty: key_read_data = {.., overflow, 1'b0, 8'd0} and the pointers are unchanged;
  - the overflow bit is cleared on the same pop;
  - key_read_data holds its value between pops.
- Full: a push when count == DEPTH is dropped; overflow is set and stays set until the next pop.
- Simultaneous push and pop:
  - if not empty: both happen and count is unchanged;
  - if empty: the pop returns valid=0 and the push still lands;
  - if full: the pop frees a slot and the push is accepted; no overflow.
- Bytes with ascii == 0 (break codes, modifiers) are never pushed.
- IRQ FSM:
  - IDLE: interrupt_vector = 0. Go to PEND when count != 0.
  - PEND: interrupt_vector = KEY_VECTOR. Go to ACKED when interrupt_ack = 1; vector is 0 from the next cycle.
  - ACKED: interrupt_vector = 0. Go to IDLE when interrupt_ack = 0; the IRQ then re-raises if entries remain.
  - The FSM does not pop the FIFO; the ISR reads Key_base to drain it.
- fifo_count is registered and equals the post-update occupancy.

Decomposition:
- Shared header adds:
  - `Key_base`;
  - `KEY_VECTOR`;
  - bit positions `KEY_VALID_BIT` (8) and `KEY_OVF_BIT` (9).
- One sub-module, sync_fifo:
  - generic width/depth circular buffer with push/pop/full/empty/count.
- The top of this block holds the edge detectors, the read-word register and the IRQ FSM.

Test Plan:
- Reset, then one read of Key_base -> key_read_data = 64'h000 (valid=0); interrupt_vector = 0.
- Press 'A' (ascii 8'h41, key_pressed held 100 cycles) -> count = 1; interrupt_vector = 1 within 2 cycles. A read strobe held 50 cycles -> key_read_data = 64'h141 and count = 0 (single pop).
- Push 9 keys 8'h61..8'h69 with DEPTH=8 -> count = 8; the first read returns 64'h361 (overflow set); the second returns 64'h162 (overflow cleared); reads 3–8 return 'c'..'h'; the ninth returns valid=0.
- IRQ handshake: FIFO holds 2 bytes; assert interrupt_ack -> vector drops to 0. Drop ack without reading -> vector returns to 1 one cycle after IDLE.
- Push edge and pop edge in the same cycle:
  - at count 8: count stays 8, overflow = 0;
  - at count 0: read returns valid=0 and count becomes 1.
- Assert KEY0 low mid-read and with count = 5 -> all outputs are 0 immediately, the FSM is in IDLE, and the next read returns valid=0.
